alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to execute one operation.
REQ-004 SHALL have port aluSel, input, 4, operation select from ALU control decode.
REQ-005 SHALL have port aluSrc, input, 1, operand B select: 0 = rt, 1 = imm.
REQ-006 SHALL have ports rs, rt, imm, input, 32 each; imm is already sign-extended.
REQ-007 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port result, output, 32, operation result.
REQ-010 SHALL have ports carry, zero, sign, output, 1 each, result flags.

Function
REQ-011 SHALL latch opA = rs, opB = (aluSrc ? imm : rt) and aluSel on the start edge; later input changes SHALL have no effect until the next accepted start.
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored and not queued.
REQ-014 Single-cycle ops: IDLE+start -> DONE; done = 1 in the cycle after the start edge.
REQ-015 aluSel 0000 ADD: result = opA + opB mod 2^32; carry = bit-32 carry-out.
REQ-016 aluSel 0001 COMP: result = ~opB + 1; carry = 0.
REQ-017 aluSel 0010 AND, 0011 XOR: bitwise opA, opB; carry = 0.
REQ-018 aluSel 0100 SHL, 0101 SHR logical, 0110 SRA: shift opA by n = opB[4:0], one bit per cycle in SHIFT.
REQ-019 Shift with n > 0: IDLE -> SHIFT for exactly n cycles -> DONE; done is asserted n+1 cycles after the start edge.
REQ-020 Shift with n = 0: IDLE -> DONE directly; result = opA, carry = 0.
REQ-021 Shift carry SHALL be the last bit shifted out; SRA SHALL replicate bit 31.
REQ-022 aluSel 1001 DIFF: result = index (0..31) of the least-significant set bit of opA ^ opB; result = 32 if opA == opB; carry = 0.
REQ-023 aluSel 1000 PASS: result = opB; carry = 0.
REQ-024 aluSel 1111 and all other codes SHALL be NOP: single-cycle, done pulses, result and flags unchanged.
REQ-025 zero = (result == 0) and sign = result[31], updated together with result in the DONE cycle (except NOP).
REQ-026 result and flags SHALL hold their values until the next non-NOP completion.
REQ-027 DONE -> IDLE unconditionally after one cycle; the earliest next start is accepted in the cycle following done.

Reset
REQ-028 rst_n low SHALL immediately force state = IDLE, busy = 0, done = 0, result = 0, carry = zero = sign = 0.
REQ-029 Reset during SHIFT or DONE SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-030 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031 ADD: rs = 0xFFFFFFFF, rt = 1, aluSrc = 0 -> done one cycle after start, result = 0, carry = 1, zero = 1.
REQ-032 SRA: rs = 0x80000000, imm = 4, aluSrc = 1, aluSel = 0110 -> busy for 5 cycles, done at start+5, result = 0xF8000000, sign = 1, carry = 0.
REQ-033 DIFF: rs = 0x000000F0, rt = 0x000000B0 -> result = 6; repeat with rs = rt -> result = 32.
REQ-034 During a SHL by 10, pulse start with aluSel = 0000 -> ignored; only one done, carrying the SHL result.
REQ-035 Assert rst_n low in the third SHIFT cycle -> busy, done and result are 0 at once, and no done appears after release.
REQ-036 COMP with rt = 5 -> result = 0xFFFFFFFB, sign = 1; SHL with n = 0 -> done at start+1, result = rs, carry = 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execution unit with bit-serial shifter
//
// Purpose:
//   Executes one ALU operation per accepted start. Most operations complete in a
//   single cycle. Shifts step one bit per cycle through the SHIFT state. Result
//   and flags are registered and hold until the next non-NOP completion.
//
// Ports:
//   clk     in   1   sole clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request to execute one operation (accepted only when idle)
//   aluSel  in   4   operation select
//   aluSrc  in   1   operand B select: 0 = rt, 1 = imm
//   rs      in  32   operand A
//   rt      in  32   operand B candidate (register)
//   imm     in  32   operand B candidate (sign-extended immediate)
//   busy    out  1   operation in flight
//   done    out  1   one-cycle pulse, result and flags valid
//   result  out 32   operation result
//   carry   out  1   carry-out / last bit shifted out
//   zero    out  1   result == 0
//   sign    out  1   result[31]

module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  aluSel,
  input  logic        aluSrc,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] imm,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry,
  output logic        zero,
  output logic        sign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_COMP = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_DIFF = 4'b1001;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_result;
  logic        r_carry;
  logic        r_zero;
  logic        r_sign;

  // Shifter working state: operand A is latched here on start and shifted in place.
  logic [31:0] r_shreg;
  logic [4:0]  r_cnt;
  logic [1:0]  r_shop;     // low bits of the shift opcode: 00 SHL, 01 SHR, 10 SRA

  logic [31:0] w_opb;
  logic        w_accept;
  logic        w_is_shift;
  logic [4:0]  w_n;
  logic        w_go_shift;

  logic [31:0] w_alu_res;
  logic        w_alu_carry;
  logic        w_alu_write;

  logic [31:0] w_diff;
  logic [5:0]  w_diff_idx;

  logic [31:0] w_sh_next;
  logic        w_sh_out;
  logic        w_sh_last;

  assign w_opb      = aluSrc ? imm : rt;
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_is_shift = (aluSel == OP_SHL) || (aluSel == OP_SHR) || (aluSel == OP_SRA);
  assign w_n        = w_opb[4:0];
  assign w_go_shift = w_is_shift && (w_n != 5'd0);
  assign w_sh_last  = (r_state == S_SHIFT) && (r_cnt == 5'd1);

  // Index of the least-significant differing bit; 32 when operands are equal.
  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    w_diff     = rs ^ w_opb;
    w_diff_idx = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (w_diff[i]) begin
        w_diff_idx = 6'(i);
      end
    end
  end

  // Single-cycle datapath, evaluated on the start edge directly from the inputs.
  // Shifts land here only for n = 0, where the result is operand A unchanged.
  always_comb begin
    w_alu_res   = 32'd0;
    w_alu_carry = 1'b0;
    w_alu_write = 1'b1;
    case (aluSel)
      OP_ADD:                 {w_alu_carry, w_alu_res} = {1'b0, rs} + {1'b0, w_opb};
      OP_COMP:                w_alu_res = ~w_opb + 32'd1;
      OP_AND:                 w_alu_res = rs & w_opb;
      OP_XOR:                 w_alu_res = rs ^ w_opb;
      OP_SHL, OP_SHR, OP_SRA: w_alu_res = rs;
      OP_PASS:                w_alu_res = w_opb;
      OP_DIFF:                w_alu_res = {26'd0, w_diff_idx};
      default:                w_alu_write = 1'b0;
    endcase
  end

  // One shift step; w_sh_out is the bit leaving the register this cycle.
  always_comb begin
    w_sh_next = r_shreg;
    w_sh_out  = 1'b0;
    case (r_shop)
      2'b00: begin
        w_sh_next = {r_shreg[30:0], 1'b0};
        w_sh_out  = r_shreg[31];
      end
      2'b01: begin
        w_sh_next = {1'b0, r_shreg[31:1]};
        w_sh_out  = r_shreg[0];
      end
      default: begin
        w_sh_next = {r_shreg[31], r_shreg[31:1]};
        w_sh_out  = r_shreg[0];
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_go_shift ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_result <= 32'd0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_sign   <= 1'b0;
      r_shreg  <= 32'd0;
      r_cnt    <= 5'd0;
      r_shop   <= 2'b00;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_shreg <= rs;
        r_cnt   <= w_n;
        r_shop  <= aluSel[1:0];
        // Non-shift (and zero-length shift) results are committed on the start
        // edge so they are visible in the DONE cycle; NOP commits nothing.
        if (!w_go_shift && w_alu_write) begin
          r_result <= w_alu_res;
          r_carry  <= w_alu_carry;
          r_zero   <= (w_alu_res == 32'd0);
          r_sign   <= w_alu_res[31];
        end
      end

      if (r_state == S_SHIFT) begin
        r_shreg <= w_sh_next;
        r_cnt   <= r_cnt - 5'd1;
      end

      // The final shift step writes straight into the result registers.
      if (w_sh_last) begin
        r_result <= w_sh_next;
        r_carry  <= w_sh_out;
        r_zero   <= (w_sh_next == 32'd0);
        r_sign   <= w_sh_next[31];
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign sign   = r_sign;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluSel;
  logic        aluSrc;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] imm;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        sign;

  int n_tests;
  int n_fail;

  // Architectural result state the model expects the DUT to hold.
  logic [31:0] e_res;
  logic        e_c;
  logic        e_z;
  logic        e_s;

  alu_exec_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .aluSel (aluSel),
    .aluSrc (aluSrc),
    .rs     (rs),
    .rt     (rt),
    .imm    (imm),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .sign   (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result, carry, whether it writes, and latency in cycles
  // from the start edge to the done cycle.
  function automatic void ref_op(input logic [3:0] sel, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r,
                                 output logic c, output logic wr, output int lat);
    int n;
    logic [32:0] s;
    n   = int'(b[4:0]);
    r   = 32'd0;
    c   = 1'b0;
    wr  = 1'b1;
    lat = 1;
    case (sel)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      4'h1: r = 32'd0 - b;
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      4'h4: begin r = a << n; if (n > 0) c = a[32 - n]; lat = n + 1; end
      4'h5: begin r = a >> n; if (n > 0) c = a[n - 1]; lat = n + 1; end
      4'h6: begin r = $unsigned($signed(a) >>> n); if (n > 0) c = a[n - 1]; lat = n + 1; end
      4'h8: r = b;
      4'h9: begin
        r = 32'd32;
        for (int i = 0; i < 32; i++) begin
          if (a[i] != b[i]) begin
            r = i;
            break;
          end
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Issues one op from idle, scrambles inputs after the start edge, waits for
  // done (bounded), then steps one cycle to confirm return to idle.
  task automatic run_op(input logic [3:0] sel, input logic src, input logic [31:0] a,
                        input logic [31:0] t, input logic [31:0] im,
                        output int lat, output logic busy_ok, output logic [31:0] o_res,
                        output logic [2:0] o_fl, output logic idle_ok);
    @(negedge clk);
    aluSel = sel; aluSrc = src; rs = a; rt = t; imm = im; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs = $urandom; rt = $urandom; imm = $urandom;
    aluSel = 4'($urandom); aluSrc = 1'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat <= 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    if (!busy) busy_ok = 1'b0;
    o_res = result;
    o_fl  = {carry, zero, sign};
    @(posedge clk);
    #1;
    idle_ok = !busy && !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; aluSel = 4'h0; aluSrc = 1'b0;
    rs = 32'd0; rt = 32'd0; imm = 32'd0;
    #1;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    n_tests++;
    if ({result, carry, zero, sign} !== 35'd0) begin
      n_fail++; $display("FAIL reset_result_flags: got %h %b expected 0", result, {carry, zero, sign});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e_res = 32'd0; e_c = 1'b0; e_z = 1'b0; e_s = 1'b0;
  endtask

  task automatic test_directed();
    int lat; logic bok, iok; logic [31:0] r; logic [2:0] fl;

    run_op(4'h0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, lat, bok, r, fl, iok);
    n_tests++;
    if (lat !== 1 || r !== 32'd0 || fl !== 3'b110) begin
      n_fail++; $display("FAIL add_wrap: lat %0d res %h czs %b expected lat 1 res 0 czs 110", lat, r, fl);
    end

    run_op(4'h6, 1'b1, 32'h8000_0000, 32'h0, 32'd4, lat, bok, r, fl, iok);
    n_tests++;
    if (lat !== 5 || bok !== 1'b1 || r !== 32'hF800_0000 || fl !== 3'b001) begin
      n_fail++; $display("FAIL sra_4: lat %0d busy_ok %b res %h czs %b expected 5 1 f8000000 001", lat, bok, r, fl);
    end
    n_tests++;
    if (iok !== 1'b1) begin
      n_fail++; $display("FAIL sra_idle_after: got %b expected 1", iok);
    end

    run_op(4'h9, 1'b0, 32'h0000_00F0, 32'h0000_00B0, 32'd0, lat, bok, r, fl, iok);
    n_tests++;
    if (lat !== 1 || r !== 32'd6 || fl !== 3'b000) begin
      n_fail++; $display("FAIL diff_6: lat %0d res %h czs %b expected 1 6 000", lat, r, fl);
    end

    run_op(4'h9, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'd0, lat, bok, r, fl, iok);
    n_tests++;
    if (r !== 32'd32 || fl !== 3'b000) begin
      n_fail++; $display("FAIL diff_equal: res %h czs %b expected 20 000", r, fl);
    end

    run_op(4'h1, 1'b0, 32'h0, 32'd5, 32'd0, lat, bok, r, fl, iok);
    n_tests++;
    if (lat !== 1 || r !== 32'hFFFF_FFFB || fl !== 3'b001) begin
      n_fail++; $display("FAIL comp_5: lat %0d res %h czs %b expected 1 fffffffb 001", lat, r, fl);
    end

    // imm = 32 has shift amount 0 in its low five bits.
    run_op(4'h4, 1'b1, 32'h1234_5678, 32'h0, 32'd32, lat, bok, r, fl, iok);
    n_tests++;
    if (lat !== 1 || r !== 32'h1234_5678 || fl !== 3'b000) begin
      n_fail++; $display("FAIL shl_0: lat %0d res %h czs %b expected 1 12345678 000", lat, r, fl);
    end

    run_op(4'hF, 1'b0, 32'h0, 32'h0, 32'h0, lat, bok, r, fl, iok);
    n_tests++;
    if (lat !== 1 || r !== 32'h1234_5678 || fl !== 3'b000) begin
      n_fail++; $display("FAIL nop_hold: lat %0d res %h czs %b expected 1 12345678 000", lat, r, fl);
    end
    e_res = 32'h1234_5678; e_c = 1'b0; e_z = 1'b0; e_s = 1'b0;
  endtask

  task automatic test_back_to_back();
    // start held high: each idle cycle accepts, so done toggles every cycle.
    @(negedge clk);
    aluSel = 4'h8; aluSrc = 1'b0; rs = 32'h0; rt = 32'hCAFE_0001; imm = 32'h0; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (done !== ((i % 2) == 0)) begin
        n_fail++; $display("FAIL b2b_done_%0d: got %b expected %b", i, done, ((i % 2) == 0));
      end
    end
    start = 1'b0;
    n_tests++;
    if (result !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL b2b_result: got %h expected cafe0001", result);
    end
    e_res = 32'hCAFE_0001; e_c = 1'b0; e_z = 1'b0; e_s = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    logic [31:0] a, r; logic c, wr; int lat, ndone, first;
    logic [31:0] got;
    a = $urandom;
    ref_op(4'h4, a, 32'd10, r, c, wr, lat);
    @(negedge clk);
    aluSel = 4'h4; aluSrc = 1'b1; rs = a; rt = 32'h0; imm = 32'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; first = -1; got = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) begin
        aluSel = 4'h0; rs = $urandom; rt = $urandom; start = 1'b1;
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) begin first = i; got = result; end
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (ndone !== 1 || first !== lat) begin
      n_fail++; $display("FAIL ignore_start_done: count %0d at %0d expected 1 at %0d", ndone, first, lat);
    end
    n_tests++;
    if (got !== r) begin
      n_fail++; $display("FAIL ignore_start_result: got %h expected %h", got, r);
    end
    e_res = r; e_c = c; e_z = (r == 32'd0); e_s = r[31];
  endtask

  task automatic test_reset_abort();
    int lat, ndone; logic bok, iok; logic [31:0] r; logic [2:0] fl;
    run_op(4'h8, 1'b0, 32'h0, 32'hA5A5_A5A5, 32'h0, lat, bok, r, fl, iok);
    @(negedge clk);
    aluSel = 4'h4; aluSrc = 1'b1; rs = 32'h0000_0F0F; imm = 32'd8; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done} !== 2'b00 || result !== 32'd0 || {carry, zero, sign} !== 3'b000) begin
      n_fail++; $display("FAIL abort_reset: busy %b done %b res %h czs %b expected 0 0 0 000", busy, done, result, {carry, zero, sign});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL abort_no_done: active cycles %0d expected 0", ndone);
    end
    // Start presented as reset releases must be taken on the very next edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    aluSel = 4'h8; aluSrc = 1'b0; rt = 32'h0BAD_F00D; start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || result !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL first_start_after_reset: done %b res %h expected 1 0badf00d", done, result);
    end
    e_res = 32'h0BAD_F00D; e_c = 1'b0; e_z = 1'b0; e_s = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [3:0] codes [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'h7, 4'hF, 4'hA};
    logic [3:0] sel; logic src, c, wr, bok, iok; logic [31:0] a, t, im, r, got; logic [2:0] fl;
    int elat, lat;
    for (int k = 0; k < 120; k++) begin
      sel = codes[$urandom_range(0, 11)];
      src = 1'($urandom_range(0, 1));
      a = $urandom; t = $urandom; im = $urandom;
      if ($urandom_range(0, 7) == 0) begin t = a; im = a; end
      if ($urandom_range(0, 7) == 0) begin t = 32'h0; im = 32'h0; a = 32'h0; end
      ref_op(sel, a, src ? im : t, r, c, wr, elat);
      if (wr) begin e_res = r; e_c = c; e_z = (r == 32'd0); e_s = r[31]; end
      run_op(sel, src, a, t, im, lat, bok, got, fl, iok);
      n_tests++;
      if (lat !== elat || bok !== 1'b1 || iok !== 1'b1) begin
        n_fail++; $display("FAIL rand_timing_%0d sel %h: lat %0d busy_ok %b idle_ok %b expected %0d 1 1", k, sel, lat, bok, iok, elat);
      end
      n_tests++;
      if (got !== e_res || fl !== {e_c, e_z, e_s}) begin
        n_fail++; $display("FAIL rand_result_%0d sel %h a %h b %h: res %h czs %b expected %h %b", k, sel, a, src ? im : t, got, fl, e_res, {e_c, e_z, e_s});
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
